led_matrix_scroller: RTL and testbench

// Upstream feeder for the 8x4 LED matrix scan driver. Holds a message of MSG_LEN 8-bit columns in RAM.

---
 rtl/led_matrix_pkg.sv | 17 +
 rtl/msg_ram.sv | 36 +++
 rtl/led_matrix_scroller.sv | 191 +++++++++++++++++++
 tb/tb_led_matrix_scroller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the 8x4 LED matrix datapath (scroller and scan driver).
// Contents:
//   NCOLS / NROWS / FRAME_W - matrix geometry and packed frame width
//   scroll_state_t          - frame-update sequencer states of the scroller
package led_matrix_pkg;

    localparam int NCOLS   = 4;
    localparam int NROWS   = 8;
    localparam int FRAME_W = NCOLS * NROWS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_COMMIT = 2'd2
    } scroll_state_t;

endpackage

// File: rtl/msg_ram.sv
// Message column store: synchronous 1-write / 1-read RAM, DEPTH x DW.
// A read that collides with a write to the same address returns the old word.
// No reset on the array or the read register so the tools can map it to block RAM.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write word
//   rd_addr  - read address, sampled every clock
//   rd_data  - registered read word (1-cycle latency)
module msg_ram #(
    parameter int    DEPTH     = 16,
    parameter int    AW        = 4,
    parameter int    DW        = 8,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Read and write in one block: the read samples the array before the
    // write lands, which gives read-old-data on a same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/led_matrix_scroller.sv
// Scrolling window feeder for the 8x4 LED matrix scan driver.
// Holds MSG_LEN message columns in RAM and presents a 4-column window as a
// 32-bit frame. The window advances one column per DIV clocks (while run=1).
// The frame register only changes on a frame_sync pulse, so the scan never
// shows a half-updated image.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   run          - prescaler enable
//   dir          - 0: window moves left (pos+1), 1: right (pos-1)
//   wr_en/wr_addr/wr_data - runtime message column write
//   frame_sync   - end-of-scan pulse from the scan driver
//   frame        - col c at frame[8c+7:8c]
//   frame_valid  - 1-cycle pulse when frame is updated
//   pos          - message column shown in col 0
module led_matrix_scroller
    import led_matrix_pkg::*;
#(
    parameter int    MSG_LEN   = 16,
    parameter int    DIV       = 1200000,
    parameter string INIT_FILE = "message.hex",
    localparam int   AW        = $clog2(MSG_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               dir,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [NROWS-1:0]   wr_data,
    input  logic               frame_sync,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    output logic [AW-1:0]      pos
);

    localparam int         PW     = $clog2(DIV);
    localparam logic [AW:0] LEN_W  = (AW+1)'(MSG_LEN);
    localparam logic [AW:0] LEN_M1 = (AW+1)'(MSG_LEN - 1);

    generate
        if (MSG_LEN < 4) begin : g_bad_len
            $error("led_matrix_scroller: MSG_LEN must be >= 4");
        end
        if (DIV < 2) begin : g_bad_div
            $error("led_matrix_scroller: DIV must be >= 2");
        end
    endgenerate

    // Operand is always below 2*MSG_LEN, so one conditional subtract suffices.
    function automatic logic [AW-1:0] wrap_len(input logic [AW:0] v);
        return (v >= LEN_W) ? AW'(v - LEN_W) : AW'(v);
    endfunction

    scroll_state_t      state_reg, state_next;
    logic [PW-1:0]      presc_reg;
    logic               step_pending_reg;
    logic               dirty_reg;
    logic [AW-1:0]      pos_reg;
    logic [2:0]         fetch_cnt_reg;
    logic [FRAME_W-1:0] frame_reg;
    logic               frame_valid_reg;

    logic               terminal;
    logic               take_step;
    logic               start_fetch;
    logic               commit;
    logic [AW-1:0]      pos_step;
    logic [AW-1:0]      rd_addr;
    logic [NROWS-1:0]   rd_data;
    logic [FRAME_W-1:0] shadow_flat;

    assign terminal = run && (presc_reg == PW'(DIV - 1));
    assign pos_step = dir ? wrap_len({1'b0, pos_reg} + LEN_M1)
                          : wrap_len({1'b0, pos_reg} + (AW+1)'(1));
    assign rd_addr  = wrap_len({1'b0, pos_reg} + (AW+1)'(fetch_cnt_reg[1:0]));

    msg_ram #(
        .DEPTH     (MSG_LEN),
        .AW        (AW),
        .DW        (NROWS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // A terminal count arriving on the same IDLE sync is treated as pending.
    always_comb begin
        state_next  = state_reg;
        take_step   = 1'b0;
        start_fetch = 1'b0;
        commit      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (frame_sync && (step_pending_reg || terminal)) begin
                    take_step   = 1'b1;
                    start_fetch = 1'b1;
                    state_next  = ST_FETCH;
                end else if (frame_sync && dirty_reg) begin
                    start_fetch = 1'b1;
                    state_next  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetch_cnt_reg == 3'd4) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (frame_sync) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg        <= '0;
            step_pending_reg <= 1'b0;
            dirty_reg        <= 1'b1;
            pos_reg          <= '0;
            fetch_cnt_reg    <= '0;
            frame_reg        <= '0;
            frame_valid_reg  <= 1'b0;
        end else begin
            if (run) begin
                presc_reg <= terminal ? '0 : presc_reg + PW'(1);
            end
            // Terminals that pile up before a step collapse into one.
            if (take_step) begin
                step_pending_reg <= 1'b0;
            end else if (terminal) begin
                step_pending_reg <= 1'b1;
            end
            // A write wins over the clear so it is never lost.
            if (wr_en) begin
                dirty_reg <= 1'b1;
            end else if (start_fetch) begin
                dirty_reg <= 1'b0;
            end
            if (take_step) begin
                pos_reg <= pos_step;
            end
            if (start_fetch) begin
                fetch_cnt_reg <= '0;
            end else if (state_reg == ST_FETCH) begin
                fetch_cnt_reg <= fetch_cnt_reg + 3'd1;
            end
            if (commit) begin
                frame_reg <= shadow_flat;
            end
            frame_valid_reg <= commit;
        end
    end

    // Read for column c is issued at fetch count c and lands at count c+1.
    genvar gi;
    generate
        for (gi = 0; gi < NCOLS; gi++) begin : g_col
            logic [NROWS-1:0] col_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    col_reg <= '0;
                end else if ((state_reg == ST_FETCH) && (fetch_cnt_reg == 3'(gi + 1))) begin
                    col_reg <= rd_data;
                end
            end
            assign shadow_flat[NROWS*gi +: NROWS] = col_reg;
        end
    endgenerate

    assign frame       = frame_reg;
    assign frame_valid = frame_valid_reg;
    assign pos         = pos_reg;

endmodule

// File: tb/tb_led_matrix_scroller.sv
module tb_led_matrix_scroller;

    localparam int L     = 6;
    localparam int DIV   = 5;
    localparam int AW    = 3;
    localparam int SYNCP = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          dir;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_sync;
    logic [31:0]   frame;
    logic          frame_valid;
    logic [AW-1:0] pos;

    always #5 clk = ~clk;

    led_matrix_scroller #(
        .MSG_LEN   (L),
        .DIV       (DIV),
        .INIT_FILE ("")
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .dir         (dir),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_sync  (frame_sync),
        .frame       (frame),
        .frame_valid (frame_valid),
        .pos         (pos)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_frames = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] frame;
        int          pos;
    } exp_t;
    exp_t sb[$];

    logic [7:0]  m_mem [L];
    int          m_pc, m_pos, m_fetch_left;
    bit          m_pend, m_dirty, m_valid, m_awaiting;
    logic [31:0] m_shown, m_inflight;

    function automatic logic [31:0] window(input int p);
        logic [31:0] f;
        for (int c = 0; c < 4; c++) f[8*c +: 8] = m_mem[(p + c) % L];
        return f;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_pos = 0; m_fetch_left = 0;
        m_pend = 0; m_dirty = 1; m_valid = 0; m_awaiting = 0;
        m_shown = '0;
        sb.delete();
    endtask

    // Called once per rising edge with the inputs that edge samples.
    task automatic model_step();
        bit term, stepped, start;
        m_valid = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        term    = run && (m_pc == DIV - 1);
        stepped = 0;
        start   = 0;
        if (run) m_pc = (m_pc + 1) % DIV;
        if (m_fetch_left > 0) begin
            m_fetch_left--;
            if (m_fetch_left == 0) m_awaiting = 1;
        end else if (m_awaiting) begin
            if (frame_sync) begin
                m_awaiting = 0;
                m_shown    = m_inflight;
                m_valid    = 1;
            end
        end else if (frame_sync && (m_pend || term)) begin
            m_pos   = dir ? (m_pos + L - 1) % L : (m_pos + 1) % L;
            stepped = 1;
            m_pend  = 0;
            start   = 1;
        end else if (frame_sync && m_dirty) begin
            start = 1;
        end
        if (term && !stepped) m_pend = 1;
        if (start) m_dirty = 0;
        if (wr_en) begin
            m_mem[int'(wr_addr)] = wr_data;
            m_dirty = 1;
        end
        if (start) begin
            m_inflight   = window(m_pos);
            m_fetch_left = 5;
            sb.push_back('{frame: m_inflight, pos: m_pos});
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("pos", 32'(pos), 32'(m_pos));
            check("frame_valid", 32'(frame_valid), 32'(m_valid));
            check("frame_held", frame, m_shown);
            if (frame_valid === 1'b1) begin
                n_frames++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: got 0x%08h expected no update (cycle %0d)", frame, cyc);
                end else begin
                    e = sb.pop_front();
                    check("sb_frame", frame, e.frame);
                    check("sb_pos", 32'(pos), 32'(e.pos));
                    $display("frame #%0d cycle %0d: frame=0x%08h pos=%0d", n_frames, cyc, frame, pos);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        frame_sync = (cyc % SYNCP == SYNCP - 1);
        wr_en = 1'b0;
    endtask

    task automatic run_for(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write_col(input int a, input logic [7:0] d);
        while (cyc % SYNCP != 10) cycle();
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        cycle();
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; run = 1'b0; dir = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; frame_sync = 1'b0;
        for (int i = 0; i < L; i++) m_mem[i] = '0;
        model_reset();
        run_for(3);
        check("reset_frame", frame, 32'h0);
        check("reset_valid", 32'(frame_valid), 32'h0);
        check("reset_pos", 32'(pos), 32'h0);
        rst_n = 1'b1;

        // Test 1: load message, first sync fetches, second commits 0x08040201.
        for (int i = 0; i < L; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'(1 << i);
            cycle();
        end
        run_for(60);

        // Test 2/3: scroll left through the wrap, then right.
        run = 1'b1; dir = 1'b0;
        run_for(14 * SYNCP);
        dir = 1'b1;
        run_for(6 * SYNCP);

        // Randomized run/dir/writes; run gating shifts terminal phase vs sync.
        for (int k = 0; k < 40; k++) begin
            dir = 1'($urandom_range(0, 1));
            for (int i = 0; i < SYNCP; i++) begin
                run = ($urandom_range(0, 3) != 0);
                if ((cyc % SYNCP) >= 8 && (cyc % SYNCP) <= 15 && $urandom_range(0, 7) == 0) begin
                    wr_en = 1'b1;
                    wr_addr = AW'($urandom_range(0, L - 1));
                    wr_data = 8'($urandom);
                end
                cycle();
            end
        end

        // Test 5: frozen scroll, rewrite column 1.
        run = 1'b0;
        run_for(3 * SYNCP);
        write_col(1, 8'hAA);
        run_for(3 * SYNCP);

        // Test 6: reset two cycles into a fetch.
        write_col(3, 8'h5A);
        guard = 0;
        while (m_fetch_left != 3 && guard < 100) begin
            cycle();
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_wait: got timeout expected fetch start within 100 cycles");
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_frame", frame, 32'h0);
        check("abort_valid", 32'(frame_valid), 32'h0);
        check("abort_pos", 32'(pos), 32'h0);
        cycle();
        cycle();
        rst_n = 1'b1;
        run_for(4 * SYNCP);

        // Drain: nothing expected may be left outstanding.
        run_for(3 * SYNCP);
        check("sb_drained", 32'(sb.size()), 32'h0);
        n_cmp++;
        if (n_frames < 10) begin
            n_bad++;
            $display("FAIL frame_count: got %0d expected at least 10", n_frames);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
